video_capture: RTL and testbench

VIDEO_CAPTURE -- requirements
Module: video_capture

---
 rtl/video_capture.sv | 174 +++++++++++++++++
 tb/tb_video_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// Frame grabber: packs eight RGB565 pixels per 128-bit write word, framed by vsync.
// Optional sticky line/frame size checks are built when CAPTURE_ERR_CHK_EN is defined.
module video_capture #(
    parameter int H_DISP = 800,
    parameter int V_DISP = 600
) (
    input  logic         pixel_clk,
    input  logic         sys_rst,
    input  logic         capture_en,
    input  logic         img_vsync,
    input  logic         img_hsync,
    input  logic         img_valid,
    input  logic [15:0]  img_data,
    output logic         wr_en,
    output logic [127:0] wr_data,
    output logic         frame_start,
    output logic         frame_done,
    output logic [10:0]  h_active,
    output logic [9:0]   v_active,
    output logic         line_err,
    output logic         frame_err
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t        state, state_d;
    logic          vsync_p1, valid_p1;
    logic          vs_rise, va_fall;
    logic          start_d, done_d;
    logic [2:0]    slot;
    logic [127:0]  pack;
    logic [10:0]   pix_cnt;
    logic [9:0]    line_cnt;
    logic          unused_hsync;

    assign unused_hsync = img_hsync;

    function automatic logic [10:0] sat_inc_pix(input logic [10:0] v);
        return (&v) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc_line(input logic [9:0] v);
        return (&v) ? v : v + 10'd1;
    endfunction

    assign vs_rise = img_vsync & ~vsync_p1;
    assign va_fall = ~img_valid & valid_p1;

    // Stage p1: edge-detect history
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_p1 <= 1'b0;
            valid_p1 <= 1'b0;
        end else begin
            vsync_p1 <= img_vsync;
            valid_p1 <= img_valid;
        end
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_d;
            frame_start <= start_d;
            frame_done  <= done_d;
        end
    end

    // capture_en only matters on a vsync rise, so a mid-frame drop lets the frame finish
    always_comb begin
        state_d = state;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (capture_en) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    if (capture_en) begin
                        state_d = CAPTURE;
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    done_d = 1'b1;
                    if (capture_en) start_d = 1'b1;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1 -> output: packing, flush and line/frame counters
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_en    <= 1'b0;
            wr_data  <= '0;
            pack     <= '0;
            slot     <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            h_active <= '0;
            v_active <= '0;
        end else begin
            wr_en <= 1'b0;
            if (vs_rise) begin
                // Frame boundary outranks any pixel or partial word in flight
                if (state == CAPTURE) v_active <= line_cnt;
                pack     <= '0;
                slot     <= '0;
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (state == CAPTURE) begin
                if (img_valid) begin
                    pix_cnt <= sat_inc_pix(pix_cnt);
                    slot    <= slot + 3'd1;
                    if (slot == 3'd7) begin
                        wr_en   <= 1'b1;
                        wr_data <= {img_data, pack[111:0]};
                        pack    <= '0;
                    end else begin
                        pack[{slot, 4'b0000} +: 16] <= img_data;
                    end
                end else if (va_fall) begin
                    h_active <= pix_cnt;
                    pix_cnt  <= '0;
                    line_cnt <= sat_inc_line(line_cnt);
                    if (slot != 3'd0) begin
                        wr_en   <= 1'b1;
                        wr_data <= pack;
                        pack    <= '0;
                        slot    <= '0;
                    end
                end
            end
        end
    end

`ifdef CAPTURE_ERR_CHK_EN
    localparam logic [10:0] H_EXP = 11'(H_DISP);
    localparam logic [9:0]  V_EXP = 10'(V_DISP);

    // A frame_err found on a back-to-back boundary survives the restart clear
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else if (start_d) begin
            line_err  <= 1'b0;
            frame_err <= (state == CAPTURE) && (line_cnt != V_EXP);
        end else if (state == CAPTURE) begin
            if (vs_rise && (line_cnt != V_EXP))
                frame_err <= 1'b1;
            if (!vs_rise && va_fall && (pix_cnt != H_EXP))
                line_err <= 1'b1;
        end
    end
`else
    localparam int unused_dims = H_DISP + V_DISP;

    assign line_err  = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a reduced 16x3 raster.
module tb_video_capture;

    localparam int H = 16;
    localparam int V = 3;
`ifdef CAPTURE_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         vsync = 1'b0;
    logic         hsync = 1'b0;
    logic         valid = 1'b0;
    logic [15:0]  data = '0;
    logic         wr_en;
    logic [127:0] wr_data;
    logic         frame_start, frame_done;
    logic [10:0]  h_active;
    logic [9:0]   v_active;
    logic         line_err, frame_err;

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int dbl = 0;
    logic [127:0] last_word = '0;
    logic wr_prev = 1'b0, fs_prev = 1'b0, fd_prev = 1'b0;
    logic fs_seen, fd_seen, fs2, fd2;

    video_capture #(.H_DISP(H), .V_DISP(V)) dut (
        .pixel_clk  (clk),
        .sys_rst    (rst),
        .capture_en (en),
        .img_vsync  (vsync),
        .img_hsync  (hsync),
        .img_valid  (valid),
        .img_data   (data),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .h_active   (h_active),
        .v_active   (v_active),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt    <= wr_cnt + 1;
            last_word <= wr_data;
        end
        if ((wr_en && wr_prev) || (frame_start && fs_prev) || (frame_done && fd_prev))
            dbl <= dbl + 1;
        wr_prev <= wr_en;
        fs_prev <= frame_start;
        fd_prev <= frame_done;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int len, input logic [15:0] base);
        for (int i = 0; i < len; i++) begin
            valid = 1'b1;
            data  = base + 16'(i);
            step();
        end
        valid = 1'b0;
        data  = '0;
        step(4);
    endtask

    task automatic boundary();
        vsync = 1'b1;
        step();
        fs_seen = frame_start;
        fd_seen = frame_done;
        step();
        fs2 = frame_start;
        fd2 = frame_done;
        vsync = 1'b0;
        step(3);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_wr_en"}, 128'(wr_en), 128'd0);
        check({pfx, "_wr_data"}, wr_data, 128'd0);
        check({pfx, "_fstart"}, 128'(frame_start), 128'd0);
        check({pfx, "_fdone"}, 128'(frame_done), 128'd0);
        check({pfx, "_h_active"}, 128'(h_active), 128'd0);
        check({pfx, "_v_active"}, 128'(v_active), 128'd0);
        check({pfx, "_line_err"}, 128'(line_err), 128'd0);
        check({pfx, "_frame_err"}, 128'(frame_err), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst = 1'b1;
        #1 check_all_zero("reset");
        step(2);
        rst = 1'b0;
        step(2);

        // idle and armed-but-waiting states ignore pixels
        send_line(H, 16'h0050);
        check("idle_ignore", 128'(wr_cnt), 128'd0);
        en = 1'b1;
        step();
        send_line(H, 16'h0060);
        check("waitvs_ignore", 128'(wr_cnt), 128'd0);

        boundary();
        check("f1_start", 128'(fs_seen), 128'd1);
        check("f1_start_one_cycle", 128'(fs2), 128'd0);
        check("f1_no_done", 128'(fd_seen), 128'd0);

        // ramp 0x0001..0x0010 on the first line
        for (int i = 0; i < H; i++) begin
            valid = 1'b1;
            data  = 16'(i + 1);
            step();
            if (i == 6) check("ramp_early", 128'(wr_en), 128'd0);
            if (i == 7) begin
                check("ramp_wr_en", 128'(wr_en), 128'd1);
                check("ramp_word", wr_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
            end
        end
        valid = 1'b0;
        step();
        check("ramp_h_active", 128'(h_active), 128'(H));
        step(3);
        send_line(H, 16'h0100);
        send_line(H, 16'h0200);
        check("f1_words", 128'(wr_cnt), 128'd6);
        check("f1_last_word", last_word, 128'h020f_020e_020d_020c_020b_020a_0209_0208);
        check("f1_line_err", 128'(line_err), 128'd0);

        boundary();
        check("f1_done", 128'(fd_seen), 128'd1);
        check("f2_start_same_cycle", 128'(fs_seen), 128'd1);
        check("f1_done_one_cycle", 128'(fd2), 128'd0);
        check("f1_v_active", 128'(v_active), 128'(V));
        check("f1_frame_err", 128'(frame_err), 128'd0);

        // over-long line: 19 pixels -> 2 full words plus a 3-pixel flush
        send_line(H + 3, 16'h0300);
        check("long_words", 128'(wr_cnt), 128'd9);
        check("long_flush_word", last_word, 128'h0312_0311_0310);
        check("long_h_active", 128'(h_active), 128'(H + 3));
        check("long_line_err", 128'(line_err), 128'(ERR_EXP));

        // request dropped mid-frame: this frame still completes
        en = 1'b0;
        send_line(H, 16'h0400);
        send_line(H, 16'h0500);
        check("f2_words", 128'(wr_cnt), 128'd13);
        boundary();
        check("f2_done", 128'(fd_seen), 128'd1);
        check("f2_no_restart", 128'(fs_seen), 128'd0);
        check("f2_v_active", 128'(v_active), 128'(V));
        check("f2_line_err_sticky", 128'(line_err), 128'(ERR_EXP));

        send_line(H, 16'h0600);
        check("idle_after_done", 128'(wr_cnt), 128'd13);
        boundary();
        check("idle_vs_no_start", 128'(fs_seen), 128'd0);

        // short frame ended by vsync landing on a valid pixel
        en = 1'b1;
        step();
        boundary();
        check("f3_start", 128'(fs_seen), 128'd1);
        check("f3_line_err_clr", 128'(line_err), 128'd0);
        send_line(H, 16'h0700);
        send_line(H, 16'h0800);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            data  = 16'h0900 + 16'(i);
            step();
        end
        en    = 1'b0;
        vsync = 1'b1;
        data  = 16'h0904;
        step();
        fd_seen = frame_done;
        valid = 1'b0;
        step();
        vsync = 1'b0;
        step(3);
        check("vs_discard_partial", 128'(wr_cnt), 128'd17);
        check("f3_done", 128'(fd_seen), 128'd1);
        check("f3_v_active", 128'(v_active), 128'd2);
        check("f3_h_active", 128'(h_active), 128'(H));
        check("f3_frame_err", 128'(frame_err), 128'(ERR_EXP));

        // reset in the middle of a line
        en = 1'b1;
        step();
        boundary();
        send_line(H, 16'h0a00);
        check("f4_words", 128'(wr_cnt), 128'd19);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = 16'h0b00 + 16'(i);
            step();
        end
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        en = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 5; i < H; i++) begin
            data = 16'h0b00 + 16'(i);
            step();
        end
        valid = 1'b0;
        step(4);
        check("rst_no_wr", 128'(wr_cnt), 128'd19);
        en = 1'b1;
        step();
        send_line(H, 16'h0c00);
        check("rst_wait_vs", 128'(wr_cnt), 128'd19);
        boundary();
        check("restart_start", 128'(fs_seen), 128'd1);
        send_line(H, 16'h0d00);
        check("restart_words", 128'(wr_cnt), 128'd21);
        check("restart_word", last_word, 128'h0d0f_0d0e_0d0d_0d0c_0d0b_0d0a_0d09_0d08);

        check("single_cycle_pulses", 128'(dbl), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
